// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Sequences a WIDTH-bit add or subtract (WIDTH = 4*NIBBLES) through one shared,
// purely combinational external 4-bit adder slice. One nibble is processed per
// clock, starting with the least significant nibble. Subtraction is done as
// A + ~B + 1: B is inverted when latched and the initial carry is set to 1.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   start      in   1      request; operands latched when accepted (IDLE/DONE)
//   sub        in   1      0: A+B, 1: A-B
//   A, B       in   WIDTH  operands
//   busy       out  1      high while nibbles are being processed
//   done       out  1      one-cycle pulse when Sum/Cout/Overflow update
//   Sum        out  WIDTH  result, held until the next completion
//   Cout       out  1      carry out of the MSB (sub: 1 = no borrow)
//   Overflow   out  1      signed overflow of the WIDTH-bit operation
//   slice_a    out  4      current A nibble to the slice
//   slice_b    out  4      current (possibly inverted) B nibble to the slice
//   slice_cin  out  1      carry into the slice
//   slice_sum  in   4      nibble sum from the slice
//   slice_cout in   1      nibble carry out from the slice
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES,
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic              last_s;
    logic [IW-1:0]     idx_r;
    logic              carry_r;
    logic [WIDTH-1:0]  a_reg_r;
    logic [WIDTH-1:0]  b_reg_r;
    logic [WIDTH-1:0]  work_r;
    logic [WIDTH-1:0]  work_s;
    logic              ovf_s;
    logic [IW+1:0]     bit_ofs_s;

    // Bit offset of the nibble currently being processed.
    assign bit_ofs_s = {idx_r, 2'b00};

    // Next-state decode; accept_s marks an operand latch, last_s the completion edge.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s  = S_ADD;
                    accept_s = 1'b1;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_ADD: begin
                if (idx_r == LAST_IDX) begin
                    state_s = S_DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = S_ADD;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Drive the slice from the latched operands; quiet (all zero) outside ADD.
    always_comb begin
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        if (state_r == S_ADD) begin
            slice_a   = a_reg_r[bit_ofs_s +: 4];
            slice_b   = b_reg_r[bit_ofs_s +: 4];
            slice_cin = carry_r;
        end else begin
            slice_a   = 4'h0;
            slice_b   = 4'h0;
            slice_cin = 1'b0;
        end
    end

    // Work register with the current nibble merged in; on the last nibble this
    // is the complete result (also covers NIBBLES=1 with no lower bits).
    always_comb begin
        work_s = work_r;
        work_s[bit_ofs_s +: 4] = slice_sum;
    end

    // Signed overflow: operands (B already inverted for sub) agree in sign,
    // result sign differs.
    assign ovf_s = (a_reg_r[WIDTH-1] == b_reg_r[WIDTH-1]) &&
                   (slice_sum[3] != a_reg_r[WIDTH-1]);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand, carry, work and result registers plus registered handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            a_reg_r  <= '0;
            b_reg_r  <= '0;
            work_r   <= '0;
        end else begin
            busy <= (state_s == S_ADD);
            done <= last_s;
            if (accept_s) begin
                a_reg_r <= A;
                b_reg_r <= sub ? ~B : B;
                carry_r <= sub;
                idx_r   <= '0;
            end else if (state_r == S_ADD) begin
                work_r  <= work_s;
                carry_r <= slice_cout;
                idx_r   <= last_s ? '0 : idx_r + IW'(1'b1);
                if (last_s) begin
                    Sum      <= work_s;
                    Cout     <= slice_cout;
                    Overflow <= ovf_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for nibble_serial_adder_ctrl (NIBBLES=4) with an ideal 4-bit adder
// slice. Expected results are queued when an operation is launched and
// compared by a monitor whenever done is seen. Handshake timing and slice
// drive values are checked inline by the directed sequence.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_cin;
    logic [3:0]   slice_sum;
    logic         slice_cout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    logic [3:0] sa_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] sb_tab [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
    logic       sc_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sub        (sub),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .Sum        (Sum),
        .Cout       (Cout),
        .Overflow   (Overflow),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    // Ideal 4-bit adder slice.
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference for the random cases: two's complement add/subtract.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bn;
        logic [W:0]   full;
        exp_t         e;
        bn   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bn} + {{W{1'b0}}, s};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (a[W-1] == bn[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("Sum", {16'h0, Sum}, {16'h0, e.s});
                chk("Cout", {31'h0, Cout}, {31'h0, e.c});
                chk("Overflow", {31'h0, Overflow}, {31'h0, e.o});
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input exp_t e);
        A = a; B = b; sub = s; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
    endtask

    // Four busy cycles, then done with busy low. Optionally re-pulse start
    // in ADD at iteration rp, and optionally check the case-1 slice drive.
    task automatic expect_run(input bit chk_slice, input int rp);
        for (int i = 0; i < NIB; i++) begin
            if (i > 0) @(negedge clk);
            if (i == rp) begin
                start = 1'b1; A = 16'hAAAA; B = 16'h5555; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("busy_c%0d", i), {31'h0, busy}, 32'd1);
            chk($sformatf("done_low_c%0d", i), {31'h0, done}, 32'd0);
            if (chk_slice) begin
                chk($sformatf("slice_a_c%0d", i), {28'h0, slice_a}, {28'h0, sa_tab[i]});
                chk($sformatf("slice_b_c%0d", i), {28'h0, slice_b}, {28'h0, sb_tab[i]});
                chk($sformatf("slice_cin_c%0d", i), {31'h0, slice_cin}, {31'h0, sc_tab[i]});
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", {31'h0, done}, 32'd1);
        chk("busy_in_done", {31'h0, busy}, 32'd0);
        chk("slice_idle", {23'h0, slice_a, slice_b, slice_cin}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
        chk({tag, "_done"}, {31'h0, done}, 32'd0);
        chk({tag, "_sum"}, {16'h0, Sum}, 32'd0);
        chk({tag, "_cout_ovf"}, {30'h0, Cout, Overflow}, 32'd0);
        chk({tag, "_slice"}, {23'h0, slice_a, slice_b, slice_cin}, 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        // Case 1 with slice drive check.
        launch(16'h1234, 16'h0FFF, 1'b0, '{s: 16'h2233, c: 1'b0, o: 1'b0});
        expect_run(1'b1, -1);
        @(negedge clk);
        chk("idle_after_done", {30'h0, busy, done}, 32'd0);

        // Case 2: carry out and signed overflow on add.
        launch(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, o: 1'b0});
        expect_run(1'b0, -1);
        @(negedge clk);
        launch(16'h7FFF, 16'h0001, 1'b0, '{s: 16'h8000, c: 1'b0, o: 1'b1});
        expect_run(1'b0, -1);
        @(negedge clk);

        // Case 3: subtraction, borrow and signed overflow.
        launch(16'h0005, 16'h0007, 1'b1, '{s: 16'hFFFE, c: 1'b0, o: 1'b0});
        expect_run(1'b0, -1);
        @(negedge clk);
        launch(16'h8000, 16'h0001, 1'b1, '{s: 16'h7FFF, c: 1'b1, o: 1'b1});
        expect_run(1'b0, -1);
        @(negedge clk);

        // Case 4a: start re-pulsed in ADD is ignored.
        launch(16'h1234, 16'h0FFF, 1'b0, '{s: 16'h2233, c: 1'b0, o: 1'b0});
        expect_run(1'b0, 1);
        @(negedge clk);
        chk("no_queued_op", {30'h0, busy, done}, 32'd0);
        chk("held_sum", {16'h0, Sum}, 32'h2233);

        // Case 4b: start in the DONE cycle runs back-to-back.
        launch(16'h0100, 16'h0023, 1'b0, '{s: 16'h0123, c: 1'b0, o: 1'b0});
        expect_run(1'b0, -1);
        launch(16'h4000, 16'h4000, 1'b0, '{s: 16'h8000, c: 1'b0, o: 1'b1});
        expect_run(1'b0, -1);
        @(negedge clk);

        // Case 5: async reset during idx=2 aborts the op.
        launch(16'h1234, 16'h0FFF, 1'b0, '{s: 16'h2233, c: 1'b0, o: 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_done_after_reset_%0d", i), {30'h0, busy, done}, 32'd0);
        end
        launch(16'h0F0F, 16'h00F1, 1'b0, '{s: 16'h1000, c: 1'b0, o: 1'b0});
        expect_run(1'b0, -1);
        @(negedge clk);

        // A few random operations against the reference model.
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            launch(ra, rb, rs, model(ra, rb, rs));
            expect_run(1'b0, -1);
            @(negedge clk);
        end

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
